// File: rtl/encoder_head_pkg.sv
// Shared constants, FSM state type, head tables and saturation helper
// for the encoder sequence pooling head.
package encoder_head_pkg;

    localparam int SEQ_LEN = 30;
    localparam int DW      = 16;
    localparam int ACC_W   = 21;

    localparam logic [DW-1:0]        RECIP    = 16'd2185;
    localparam logic signed [DW:0]   RECIP_S  = {1'b0, RECIP};
    localparam logic [4:0]           LAST_CNT = 5'(SEQ_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        MEAN,
        SCALE,
        BIAS,
        OUT,
        DONE
    } state_e;

    // Entries 2..7 come from the training export; Q8.8 signed.
    localparam logic signed [DW-1:0] HEAD_W [0:7] = '{
        16'sh0100, 16'sh0200, 16'sh0080, 16'shFF00,
        16'sh0180, 16'sh0040, 16'shFE00, 16'sh0300
    };

    localparam logic signed [DW-1:0] HEAD_B [0:7] = '{
        16'sh0000, 16'sh0080, 16'sh0010, 16'sh0040,
        16'shFF80, 16'sh0000, 16'sh0100, 16'shFFF0
    };

    function automatic logic signed [DW-1:0] sat16(input logic signed [47:0] v);
        if (v > 48'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -48'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/sat_mul_shift.sv
// Signed multiply, round half up, arithmetic right shift by SHIFT,
// then saturate to a signed 16-bit result.
module sat_mul_shift
    import encoder_head_pkg::*;
#(
    parameter int AW    = 16,
    parameter int BW    = 16,
    parameter int SHIFT = 8
) (
    input  logic signed [AW-1:0] a_i,
    input  logic signed [BW-1:0] b_i,
    output logic signed [DW-1:0] y_o
);

    localparam int PW = AW + BW;
    localparam logic signed [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (SHIFT - 1);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] shifted;

    // Both operands are widened to the full product width so the multiply is exact.
    assign a_ext   = {{BW{a_i[AW-1]}}, a_i};
    assign b_ext   = {{AW{b_i[BW-1]}}, b_i};
    assign prod    = a_ext * b_ext;
    assign rounded = prod + HALF;
    assign shifted = rounded >>> SHIFT;
    assign y_o     = sat16({{(48-PW){shifted[PW-1]}}, shifted});

endmodule

// File: rtl/encoder_seq_pool_head.sv
// Temporal mean of SEQ_LEN encoder samples followed by a per-block affine
// output head; one registered result per frame.
module encoder_seq_pool_head
    import encoder_head_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_in,
    input  logic          data_in_valid,
    input  logic [2:0]    block_sel,
    output logic [DW-1:0] data_out,
    output logic          data_out_valid,
    output logic          done,
    output logic          overrun
);

    state_e                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [4:0]               cnt_q;
    logic [2:0]               sel_q;
    logic signed [DW-1:0]     mean_q;
    logic signed [DW-1:0]     prod_q;
    logic signed [DW-1:0]     res_q;
    logic [DW-1:0]            data_out_q;
    logic                     valid_q;
    logic                     done_q;
    logic                     overrun_q;

    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [DW-1:0]     mean_d;
    logic signed [DW-1:0]     prod_d;
    logic signed [DW-1:0]     res_d;
    logic signed [DW:0]       bias_sum;
    logic signed [DW-1:0]     bias_sel;

    assign sample_ext = {{(ACC_W-DW){data_in[DW-1]}}, data_in};

    sat_mul_shift #(
        .AW   (ACC_W),
        .BW   (DW + 1),
        .SHIFT(16)
    ) u_mean (
        .a_i(acc_q),
        .b_i(RECIP_S),
        .y_o(mean_d)
    );

    sat_mul_shift #(
        .AW   (DW),
        .BW   (DW),
        .SHIFT(8)
    ) u_scale (
        .a_i(mean_q),
        .b_i(HEAD_W[sel_q]),
        .y_o(prod_d)
    );

    // One guard bit is enough: the sum of two Q8.8 values fits in 17 bits.
    assign bias_sel = HEAD_B[sel_q];
    assign bias_sum = {prod_q[DW-1], prod_q} + {bias_sel[DW-1], bias_sel};
    assign res_d    = sat16({{(48-DW-1){bias_sum[DW]}}, bias_sum});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            mean_q     <= '0;
            prod_q     <= '0;
            res_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (data_in_valid) begin
                        acc_q   <= sample_ext;
                        cnt_q   <= 5'd1;
                        sel_q   <= block_sel;
                        done_q  <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (data_in_valid) begin
                        acc_q <= acc_q + sample_ext;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= MEAN;
                        end
                    end
                end
                MEAN: begin
                    if (data_in_valid) overrun_q <= 1'b1;
                    mean_q  <= mean_d;
                    state_q <= SCALE;
                end
                SCALE: begin
                    if (data_in_valid) overrun_q <= 1'b1;
                    prod_q  <= prod_d;
                    state_q <= BIAS;
                end
                BIAS: begin
                    if (data_in_valid) overrun_q <= 1'b1;
                    res_q   <= res_d;
                    state_q <= OUT;
                end
                OUT: begin
                    if (data_in_valid) overrun_q <= 1'b1;
                    data_out_q <= res_q;
                    valid_q    <= 1'b1;
                    done_q     <= 1'b1;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign done           = done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_encoder_seq_pool_head.sv
// Directed bench for encoder_seq_pool_head: a frame-level reference model
// checked every cycle, plus hand-computed result values.
module tb_encoder_seq_pool_head;

    localparam int SEQ = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [2:0]  block_sel = '0;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        done;
    logic        overrun;

    int testsRun = 0;
    int testsFailed = 0;
    int validSeen = 0;

    always #5 clk = ~clk;

    encoder_seq_pool_head dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .block_sel     (block_sel),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .done          (done),
        .overrun       (overrun)
    );

    int wTab [0:7] = '{256, 512, 128, -256, 384, 64, -512, 768};
    int bTab [0:7] = '{0, 128, 16, 64, -128, 0, 256, -16};

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Mean via the Q0.16 reciprocal, then the affine head, all in wide integers.
    function automatic logic [15:0] refResult(input longint sum, input int sel);
        longint m, p, r;
        m = sat((sum * 2185 + 32768) >>> 16);
        p = sat((m * wTab[sel] + 128) >>> 8);
        r = sat(p + bTab[sel]);
        return r[15:0];
    endfunction

    int          mCount, mBusy, mSel;
    longint      mSum;
    logic [15:0] mPending, mOut;
    logic        mValid, mDone, mOvr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCount = 0; mBusy = 0; mSel = 0; mSum = 0;
            mPending = '0; mOut = '0; mValid = 1'b0; mDone = 1'b0; mOvr = 1'b0;
        end else begin
            mValid = 1'b0;
            if (mBusy > 0) begin
                if (data_in_valid) mOvr = 1'b1;
                mBusy--;
                if (mBusy == 0) begin
                    mValid = 1'b1;
                    mOut   = mPending;
                    mDone  = 1'b1;
                end
            end else if (data_in_valid) begin
                if (mCount == 0) begin
                    mSum  = 0;
                    mSel  = int'(block_sel);
                    mDone = 1'b0;
                end
                mSum += longint'($signed(data_in));
                mCount++;
                if (mCount == SEQ) begin
                    mPending = refResult(mSum, mSel);
                    mBusy    = 4;
                    mCount   = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("valid", 32'(data_out_valid), 32'(mValid));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("overrun", 32'(overrun), 32'(mOvr));
            checkOutput("data_out", 32'(data_out), 32'(mOut));
            if (data_out_valid) validSeen++;
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [2:0] s);
        data_in       = d;
        block_sel     = s;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [15:0] base, input logic [15:0] step,
                             input logic [2:0] s0, input logic [2:0] s1, input int first);
        for (int i = first; i < SEQ; i++) begin
            applyStimulus(base + 16'(i) * step, (i == 0) ? s0 : s1);
        end
    endtask

    task automatic waitResult(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (data_out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int snap;

        #12;
        checkOutput("reset_data_out", 32'(data_out), 32'h0);
        checkOutput("reset_valid", 32'(data_out_valid), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        sendFrame(16'h0100, 16'h0000, 3'd0, 3'd0, 0);
        waitResult(cyc);
        checkOutput("lat_a", 32'(cyc), 32'd4);
        checkOutput("out_a", 32'(data_out), 32'h0100);
        checkOutput("done_a", 32'(done), 32'h1);

        applyStimulus(16'hFF00, 3'd0);
        checkOutput("done_clear", 32'(done), 32'h0);
        sendFrame(16'hFF00, 16'h0000, 3'd0, 3'd0, 1);
        waitResult(cyc);
        checkOutput("lat_b", 32'(cyc), 32'd4);
        checkOutput("out_b", 32'(data_out), 32'hFF00);

        sendFrame(16'h0000, 16'h0100, 3'd1, 3'd3, 0);
        waitResult(cyc);
        checkOutput("out_ramp", 32'(data_out), 32'h1D82);

        sendFrame(16'h7FFF, 16'h0000, 3'd1, 3'd1, 0);
        waitResult(cyc);
        checkOutput("out_sat", 32'(data_out), 32'h7FFF);

        sendFrame(16'h0100, 16'h0000, 3'd1, 3'd1, 0);
        applyStimulus(16'h1234, 3'd1);
        waitResult(cyc);
        checkOutput("lat_ovr", 32'(cyc), 32'd3);
        checkOutput("out_ovr", 32'(data_out), 32'h0280);
        checkOutput("overrun_set", 32'(overrun), 32'h1);

        sendFrame(16'h0200, 16'h0000, 3'd3, 3'd3, 0);
        waitResult(cyc);
        checkOutput("out_neg_w", 32'(data_out), 32'hFE40);
        checkOutput("overrun_sticky", 32'(overrun), 32'h1);

        repeat (2) @(posedge clk);
        #1;
        snap = validSeen;
        for (int i = 0; i < 12; i++) applyStimulus(16'h0100, 3'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_data_out", 32'(data_out), 32'h0);
        checkOutput("midrst_overrun", 32'(overrun), 32'h0);
        checkOutput("midrst_done", 32'(done), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("aborted_no_valid", 32'(validSeen), 32'(snap));

        sendFrame(16'h0100, 16'h0000, 3'd0, 3'd0, 0);
        waitResult(cyc);
        checkOutput("lat_fresh", 32'(cyc), 32'd4);
        checkOutput("out_fresh", 32'(data_out), 32'h0100);
        checkOutput("overrun_fresh", 32'(overrun), 32'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
